// File: rtl/fdc_reg_responder.sv
// rtl/fdc_reg_responder.sv - WD179x-style register responder between the CoCo bus and the AVR disk engine
module fdc_reg_responder #(
    parameter int HALT_TIMEOUT = 1024,
    parameter int TO_W         = 11
) (
    input  logic       eclk,
    input  logic       reset,
    input  logic       scs_n,
    input  logic [3:0] c_addr,
    input  logic       c_rw,
    input  logic [7:0] c_din,
    output logic [7:0] c_dout,
    input  logic [2:0] a_addr,
    input  logic       a_wr,
    input  logic       a_rd,
    input  logic [7:0] a_din,
    output logic [7:0] a_dout,
    output logic       a_regint,
    output logic       halt_n,
    output logic       nmi_n
);

    logic [7:0]      dskcon, cmd_reg, track, sector, data_reg;
    logic [4:0]      stat_hi;
    logic            busy, drq, intrq, lost, cmd_pending, xfer_evt;
    logic [TO_W-1:0] to_cnt;

    logic [7:0]      dskcon_nx, cmd_reg_nx, track_nx, sector_nx, data_reg_nx;
    logic [4:0]      stat_hi_nx;
    logic            busy_nx, drq_nx, intrq_nx, lost_nx, cmd_pending_nx, xfer_evt_nx;
    logic [TO_W-1:0] to_cnt_nx, to_inc;

    logic c_wr, c_fdc, c_rd_stat, c_data_acc;
    logic halt_req, timeout;
    logic unused_addr;

    assign unused_addr = c_addr[2];

    assign c_wr       = ~scs_n & ~c_rw;
    assign c_fdc      = ~scs_n & c_addr[3];
    assign c_rd_stat  = c_fdc & c_rw & (c_addr[1:0] == 2'd0);
    assign c_data_acc = c_fdc & (c_addr[1:0] == 2'd3);

    assign halt_req = dskcon[7] & busy & ~drq & ~intrq & ~lost;
    assign to_inc   = to_cnt + TO_W'(1);
    // Fires on the edge the counter reaches HALT_TIMEOUT-1 so halt_n is low for exactly HALT_TIMEOUT cycles.
    assign timeout  = halt_req & ~halt_n & (to_inc == TO_W'(HALT_TIMEOUT - 1));

    assign a_regint = cmd_pending | xfer_evt;

    always_comb begin
        c_dout = 8'hFF;
        if (c_addr[3]) begin
            case (c_addr[1:0])
                2'd0:    c_dout = {stat_hi, lost, drq, busy};
                2'd1:    c_dout = track;
                2'd2:    c_dout = sector;
                default: c_dout = data_reg;
            endcase
        end
    end

    always_comb begin
        case (a_addr)
            3'd0:    a_dout = dskcon;
            3'd1:    a_dout = cmd_reg;
            3'd2:    a_dout = track;
            3'd3:    a_dout = sector;
            3'd4:    a_dout = data_reg;
            3'd5:    a_dout = {stat_hi, 3'b000};
            3'd6:    a_dout = {2'b00, ~halt_n, lost, intrq, drq, busy, cmd_pending};
            default: a_dout = 8'h00;
        endcase
    end

    // Effects are applied in priority order: CoCo acknowledges and timeout, then AVR, then CoCo writes.
    always_comb begin
        dskcon_nx      = dskcon;
        cmd_reg_nx     = cmd_reg;
        track_nx       = track;
        sector_nx      = sector;
        data_reg_nx    = data_reg;
        stat_hi_nx     = stat_hi;
        busy_nx        = busy;
        drq_nx         = drq;
        intrq_nx       = intrq;
        lost_nx        = lost;
        cmd_pending_nx = cmd_pending;
        xfer_evt_nx    = xfer_evt;
        to_cnt_nx      = to_cnt;

        if (!halt_req)
            to_cnt_nx = '0;
        else if (!halt_n)
            to_cnt_nx = to_inc;

        if (c_rd_stat)
            intrq_nx = 1'b0;
        if (timeout) begin
            lost_nx  = 1'b1;
            intrq_nx = 1'b1;
            busy_nx  = 1'b0;
        end
        if (c_data_acc && drq)
            drq_nx = 1'b0;

        if (a_rd && a_addr == 3'd6)
            xfer_evt_nx = 1'b0;
        if (c_data_acc && drq)
            xfer_evt_nx = 1'b1;
        if (a_rd && a_addr == 3'd1)
            cmd_pending_nx = 1'b0;

        if (a_wr) begin
            case (a_addr)
                3'd2: track_nx  = a_din;
                3'd3: sector_nx = a_din;
                3'd4: begin
                    data_reg_nx = a_din;
                    drq_nx      = 1'b1;
                end
                3'd5: stat_hi_nx = a_din[7:3];
                3'd6: begin
                    if (a_din[0]) begin
                        busy_nx  = 1'b0;
                        drq_nx   = 1'b0;
                        intrq_nx = 1'b1;
                    end
                    if (a_din[1])
                        drq_nx = 1'b1;
                end
                default: ;
            endcase
        end

        if (c_wr) begin
            if (!c_addr[3]) begin
                dskcon_nx = c_din;
            end else begin
                case (c_addr[1:0])
                    2'd0: begin
                        cmd_reg_nx     = c_din;
                        cmd_pending_nx = 1'b1;
                        drq_nx         = 1'b0;
                        busy_nx        = (c_din[7:4] != 4'hD);
                        if (c_din[7:4] == 4'hD) begin
                            if (c_din[3])
                                intrq_nx = 1'b1;
                        end else begin
                            intrq_nx = 1'b0;
                            lost_nx  = 1'b0;
                        end
                    end
                    2'd1:    track_nx    = c_din;
                    2'd2:    sector_nx   = c_din;
                    default: data_reg_nx = c_din;
                endcase
            end
        end
    end

    always_ff @(posedge eclk or posedge reset) begin
        if (reset) begin
            dskcon      <= 8'h00;
            cmd_reg     <= 8'h00;
            track       <= 8'h00;
            sector      <= 8'h00;
            data_reg    <= 8'h00;
            stat_hi     <= 5'h00;
            busy        <= 1'b0;
            drq         <= 1'b0;
            intrq       <= 1'b0;
            lost        <= 1'b0;
            cmd_pending <= 1'b0;
            xfer_evt    <= 1'b0;
            to_cnt      <= '0;
            halt_n      <= 1'b1;
            nmi_n       <= 1'b1;
        end else begin
            dskcon      <= dskcon_nx;
            cmd_reg     <= cmd_reg_nx;
            track       <= track_nx;
            sector      <= sector_nx;
            data_reg    <= data_reg_nx;
            stat_hi     <= stat_hi_nx;
            busy        <= busy_nx;
            drq         <= drq_nx;
            intrq       <= intrq_nx;
            lost        <= lost_nx;
            cmd_pending <= cmd_pending_nx;
            xfer_evt    <= xfer_evt_nx;
            to_cnt      <= to_cnt_nx;
            halt_n      <= ~halt_req;
            nmi_n       <= ~(intrq & dskcon[7]);
        end
    end

endmodule

// File: tb/tb_fdc_reg_responder.sv
// tb/tb_fdc_reg_responder.sv - randomized and directed bench for fdc_reg_responder against a behavioural model
module tb_fdc_reg_responder;

    localparam int HT = 16;

    logic       eclk = 1'b0;
    logic       reset;
    logic       scs_n;
    logic [3:0] c_addr;
    logic       c_rw;
    logic [7:0] c_din;
    logic [7:0] c_dout;
    logic [2:0] a_addr;
    logic       a_wr;
    logic       a_rd;
    logic [7:0] a_din;
    logic [7:0] a_dout;
    logic       a_regint;
    logic       halt_n;
    logic       nmi_n;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    fdc_reg_responder #(.HALT_TIMEOUT(HT), .TO_W(5)) dut (
        .eclk(eclk), .reset(reset), .scs_n(scs_n), .c_addr(c_addr), .c_rw(c_rw),
        .c_din(c_din), .c_dout(c_dout), .a_addr(a_addr), .a_wr(a_wr), .a_rd(a_rd),
        .a_din(a_din), .a_dout(a_dout), .a_regint(a_regint), .halt_n(halt_n), .nmi_n(nmi_n)
    );

    always #10 eclk = ~eclk;

    // Behavioural model: register file plus flags; halt timing tracked as "edge at which halt went low".
    logic [7:0] m_dsk, m_cmd, m_trk, m_sec, m_dat;
    logic [4:0] m_sth;
    bit m_busy, m_drq, m_intrq, m_lost, m_cmdp, m_xfer, m_halt_n, m_nmi_n;
    int edge_i, low_since;
    bit mq, mfire, mnh, mnn, odrq, c_data, c_write;

    always @(posedge eclk or posedge reset) begin
        if (reset) begin
            m_dsk = 0; m_cmd = 0; m_trk = 0; m_sec = 0; m_dat = 0; m_sth = 0;
            m_busy = 0; m_drq = 0; m_intrq = 0; m_lost = 0; m_cmdp = 0; m_xfer = 0;
            m_halt_n = 1; m_nmi_n = 1; edge_i = 0; low_since = 0;
        end else begin
            mq    = m_dsk[7] && m_busy && !m_drq && !m_intrq && !m_lost;
            mfire = !m_halt_n && mq && (edge_i - low_since == HT - 1);
            mnh   = !mq;
            mnn   = !(m_intrq && m_dsk[7]);
            if (m_halt_n && !mnh) low_since = edge_i;
            odrq    = m_drq;
            c_data  = !scs_n && c_addr[3] && c_addr[1:0] == 2'd3;
            c_write = !scs_n && !c_rw;

            if (!scs_n && c_rw && c_addr[3] && c_addr[1:0] == 2'd0) m_intrq = 0;
            if (mfire) begin m_lost = 1; m_intrq = 1; m_busy = 0; end
            if (c_data && odrq) m_drq = 0;
            if (a_rd && a_addr == 3'd6) m_xfer = 0;
            if (c_data && odrq) m_xfer = 1;
            if (a_rd && a_addr == 3'd1) m_cmdp = 0;
            if (a_wr) begin
                if (a_addr == 3'd2) m_trk = a_din;
                if (a_addr == 3'd3) m_sec = a_din;
                if (a_addr == 3'd4) begin m_dat = a_din; m_drq = 1; end
                if (a_addr == 3'd5) m_sth = a_din[7:3];
                if (a_addr == 3'd6 && a_din[0]) begin m_busy = 0; m_drq = 0; m_intrq = 1; end
                if (a_addr == 3'd6 && a_din[1]) m_drq = 1;
            end
            if (c_write && !c_addr[3]) m_dsk = c_din;
            if (c_write && c_addr[3]) begin
                if (c_addr[1:0] == 2'd1) m_trk = c_din;
                if (c_addr[1:0] == 2'd2) m_sec = c_din;
                if (c_addr[1:0] == 2'd3) m_dat = c_din;
                if (c_addr[1:0] == 2'd0) begin
                    m_cmd = c_din; m_cmdp = 1; m_drq = 0;
                    if (c_din[7:4] == 4'hD) begin
                        m_busy = 0;
                        if (c_din[3]) m_intrq = 1;
                    end else begin
                        m_busy = 1; m_intrq = 0; m_lost = 0;
                    end
                end
            end
            m_halt_n = mnh;
            m_nmi_n  = mnn;
            edge_i++;
        end
    end

    function automatic logic [7:0] m_cdout(input logic [3:0] a);
        if (!a[3]) return 8'hFF;
        case (a[1:0])
            2'd0:    return {m_sth, m_lost, m_drq, m_busy};
            2'd1:    return m_trk;
            2'd2:    return m_sec;
            default: return m_dat;
        endcase
    endfunction

    function automatic logic [7:0] m_adout(input logic [2:0] a);
        case (a)
            3'd0:    return m_dsk;
            3'd1:    return m_cmd;
            3'd2:    return m_trk;
            3'd3:    return m_sec;
            3'd4:    return m_dat;
            3'd5:    return {m_sth, 3'b000};
            3'd6:    return {2'b00, !m_halt_n, m_lost, m_intrq, m_drq, m_busy, m_cmdp};
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge eclk) begin
        if (chk_en && !reset) begin
            chk("model c_dout", c_dout, m_cdout(c_addr));
            chk("model a_dout", a_dout, m_adout(a_addr));
            chk1("model a_regint", a_regint, m_cmdp | m_xfer);
            chk1("model halt_n", halt_n, m_halt_n);
            chk1("model nmi_n", nmi_n, m_nmi_n);
        end
    end

    task automatic idle();
        scs_n = 1'b1; a_wr = 1'b0; a_rd = 1'b0;
    endtask

    task automatic step();
        @(posedge eclk);
        #1;
    endtask

    task automatic cw(input logic [3:0] a, input logic [7:0] d);
        idle(); scs_n = 1'b0; c_addr = a; c_rw = 1'b0; c_din = d;
        step(); idle();
    endtask

    task automatic aw(input logic [2:0] a, input logic [7:0] d);
        idle(); a_addr = a; a_wr = 1'b1; a_din = d;
        step(); idle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        reset = 1'b1; idle(); c_addr = 4'h0; c_rw = 1'b1; c_din = 8'h00; a_addr = 3'd0; a_din = 8'h00;
        repeat (3) step();
        reset = 1'b0;
        chk_en = 1'b1;

        chk1("rst halt_n", halt_n, 1'b1);
        chk1("rst nmi_n", nmi_n, 1'b1);
        chk1("rst a_regint", a_regint, 1'b0);
        a_addr = 3'd6; c_addr = 4'h8; #1;
        chk("rst ctrl", a_dout, 8'h00);
        chk("rst status", c_dout, 8'h00);

        cw(4'h8, 8'h80);
        a_addr = 3'd6; #1;
        chk("t1 ctrl", a_dout, 8'h03);
        chk1("t1 regint", a_regint, 1'b1);
        a_addr = 3'd1; a_rd = 1'b1; #1;
        chk("t1 cmd", a_dout, 8'h80);
        step(); idle(); a_addr = 3'd6; c_addr = 4'h8; #1;
        chk("t1 ctrl2", a_dout, 8'h02);
        chk1("t1 regint0", a_regint, 1'b0);
        chk("t1 status", c_dout, 8'h01);

        cw(4'h0, 8'h80);
        step();
        chk1("t2 halt low", halt_n, 1'b0);
        aw(3'd4, 8'h5A);
        a_addr = 3'd6; #1;
        chk("t2 ctrl drq", a_dout, 8'h26);
        step();
        chk1("t2 halt released", halt_n, 1'b1);
        scs_n = 1'b0; c_addr = 4'hB; c_rw = 1'b1; #1;
        chk("t2 coco data", c_dout, 8'h5A);
        step(); idle();
        chk1("t2 xfer regint", a_regint, 1'b1);
        step();
        chk1("t2 halt again", halt_n, 1'b0);
        a_addr = 3'd6; a_rd = 1'b1; #1;
        chk("t2 ctrl read", a_dout, 8'h22);
        step(); idle();
        chk1("t2 xfer cleared", a_regint, 1'b0);

        aw(3'd6, 8'h01);
        a_addr = 3'd6; #1;
        chk("t3 ctrl done", a_dout, 8'h28);
        step();
        chk1("t3 nmi low", nmi_n, 1'b0);
        chk1("t3 halt high", halt_n, 1'b1);
        scs_n = 1'b0; c_addr = 4'h8; c_rw = 1'b1; #1;
        chk("t3 status", c_dout, 8'h00);
        step(); idle();
        chk1("t3 nmi still low", nmi_n, 1'b0);
        step();
        chk1("t3 nmi released", nmi_n, 1'b1);

        cw(4'h8, 8'h80);
        aw(3'd6, 8'h02);
        cw(4'h8, 8'hD8);
        a_addr = 3'd6; #1;
        chk("t4 force D8", a_dout, 8'h09);
        step();
        chk1("t4 nmi low", nmi_n, 1'b0);
        cw(4'h8, 8'h80);
        cw(4'h8, 8'hD0);
        a_addr = 3'd6; #1;
        chk("t4 force D0", a_dout, 8'h21);
        chk1("t4 D0 nmi", nmi_n, 1'b1);

        cw(4'h8, 8'h80);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (!halt_n) cnt++;
            else if (cnt > 0) break;
        end
        chk("t5 halt low cycles", 8'(cnt), 8'(HT));
        c_addr = 4'h8; c_rw = 1'b1; a_addr = 3'd6; #1;
        chk("t5 status lost", c_dout, 8'h04);
        chk("t5 ctrl", a_dout, 8'h19);
        chk1("t5 nmi low", nmi_n, 1'b0);

        idle(); scs_n = 1'b0; c_addr = 4'h9; c_rw = 1'b0; c_din = 8'h33;
        a_addr = 3'd2; a_wr = 1'b1; a_din = 8'h77;
        step(); idle(); a_addr = 3'd2; #1;
        chk("t6 track coco wins", a_dout, 8'h33);
        aw(3'd4, 8'h11);
        scs_n = 1'b0; c_addr = 4'hB; c_rw = 1'b1; a_addr = 3'd4; a_wr = 1'b1; a_din = 8'h22; #1;
        chk("t6 old data", c_dout, 8'h11);
        step(); idle(); a_addr = 3'd6; #1;
        chk("t6 new data", c_dout, 8'h22);
        chk1("t6 drq stays", a_dout[2], 1'b1);

        cw(4'h8, 8'h80);
        step();
        chk1("t6 pre-reset halt", halt_n, 1'b0);
        aw(3'd6, 8'h01);
        a_addr = 3'd4; c_addr = 4'h9; c_rw = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk1("rstA halt_n", halt_n, 1'b1);
        chk1("rstA nmi_n", nmi_n, 1'b1);
        chk1("rstA regint", a_regint, 1'b0);
        chk("rstA data", a_dout, 8'h00);
        chk("rstA track", c_dout, 8'h00);
        step(); step(); reset = 1'b0;

        cw(4'h0, 8'h80);
        cw(4'h8, 8'hD8);
        step();
        chk1("rstB nmi pre", nmi_n, 1'b0);
        a_addr = 3'd0;
        #2 reset = 1'b1;
        #1;
        chk1("rstB nmi_n", nmi_n, 1'b1);
        chk("rstB dskcon", a_dout, 8'h00);
        step(); step(); reset = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            bit quiet;
            int k;
            quiet  = (i % 500) >= 320;
            scs_n  = quiet ? ($urandom_range(0, 40) != 0) : ($urandom_range(0, 2) != 0);
            c_addr = 4'($urandom);
            c_rw   = 1'($urandom);
            case ($urandom_range(0, 4))
                0:       c_din = 8'h80;
                1:       c_din = 8'hD0 | 8'($urandom_range(0, 15));
                2:       c_din = 8'h80 | 8'($urandom_range(0, 127));
                default: c_din = 8'($urandom);
            endcase
            k      = $urandom_range(0, 7);
            a_wr   = !quiet && k == 0;
            a_rd   = !quiet && k == 1;
            a_addr = 3'($urandom);
            a_din  = 8'($urandom);
            step();
        end
        idle();
        step(); step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fdc_reg_responder.md
Name: fdc_reg_responder

Overview:
- CPLD-side WD179x-style register responder for the CoCo disk interface at $FF40-$FF4F.
- CoCo register accesses (scs_n) latch into a shadow register file, and the block posts events to the AVR over a synchronous register port.
- The AVR acts as the disk engine: it supplies status and data and signals completion.
- The block generates the CoCo-side DRQ, INTRQ, HALT and NMI behaviour that the AVR's HALT-based bus takeover logic relies on.

Parameters:
HALT_TIMEOUT, 1024, eclk cycles halt_n may stay asserted before forced release with lost-data.
TO_W, 11, timeout counter width; must satisfy 2^TO_W > HALT_TIMEOUT.

Ports:
eclk  in  1  CoCo E clock; sole clock, all logic on posedge.
reset  in  1  asynchronous active-high reset.
scs_n  in  1  CoCo SCS; each cycle it is sampled low is one register access.
c_addr  in  4  CoCo address [3:0].
c_rw  in  1  1 = CoCo read.
c_din  in  8  CoCo write data.
c_dout  out  8  CoCo read data (combinational mux of registers).
a_addr  in  3  AVR register select.
a_wr  in  1  AVR write strobe (1 cycle).
a_rd  in  1  AVR read strobe (1 cycle; side effects apply).
a_din  in  8  AVR write data.
a_dout  out  8  AVR read data (combinational).
a_regint  out  1  AVR attention = cmd_pending | xfer_evt.
halt_n  out  1  CoCo HALT, active low, registered.
nmi_n  out  1  CoCo NMI, active low, registered.

Behaviour:
Reset values:
- All registers, flags and counters are 0.
- halt_n=1, nmi_n=1, a_regint=0.

CoCo map, active when scs_n=0 on a clock edge:
- c_addr[3]=0: DSKCON latch, write-only; reads return 0xFF. Bit7 is halt_en, bits6:0 are drive/motor/density.
- c_addr[3]=1, c_addr[1:0] select the FDC register:
  - 0: read STATUS, write COMMAND.
  - 1: TRACK.
  - 2: SECTOR.
  - 3: DATA.

STATUS read value is {stat_hi[7:3], lost, drq, busy}.

CoCo write COMMAND:
- If cmd[7:4]=1101 (force interrupt): busy=0, drq=0. If cmd[3]=1, intrq=1.
- Otherwise: busy=1, drq=0, intrq=0, lost=0.
- In both cases: cmd_pending=1.

CoCo read STATUS: intrq=0.

CoCo read DATA:
- Returns data_reg.
- If drq was 1: drq=0 and xfer_evt=1.

CoCo write DATA:
- data_reg=c_din.
- If drq was 1: drq=0 and xfer_evt=1.

AVR map:
- 0: read DSKCON.
- 1: read COMMAND; read clears cmd_pending.
- 2: TRACK, read/write.
- 3: SECTOR, read/write.
- 4: DATA.
  - Read returns data_reg.
  - Write sets data_reg=a_din and drq=1.
- 5: write stat_hi=a_din[7:3].
- 6: control.
  - Write bit0=1 (done): busy=0, drq=0, intrq=1.
  - Write bit1=1: drq=1 without loading data.
  - Read returns {2'b0, halt_active, lost, intrq, drq, busy, cmd_pending}, then clears xfer_evt.
- 7: reads 0x00; writes ignored.

Collisions and side effects:
- Same-cycle CoCo and AVR write to TRACK/SECTOR/DATA: the CoCo wins.
- AVR DATA write in the same cycle as a CoCo DATA read: the CoCo gets the old data_reg, and drq ends at 1 with the new data.
- AVR done in the same cycle as a CoCo COMMAND write: the COMMAND write wins (busy=1, intrq=0).
- Reads with side effects act once per strobe/access cycle.

HALT:
- halt_req = halt_en & busy & ~drq & ~intrq & ~lost.
- halt_n = ~halt_req, registered, so it has 1 cycle of latency.
- While halt_n=0, to_cnt increments each cycle. to_cnt clears whenever halt_req=0.
- When to_cnt reaches HALT_TIMEOUT-1: lost=1, intrq=1, busy=0. halt_n returns to 1 on the next edge.

NMI:
- nmi_n = ~(intrq & halt_en), registered.
- Clearing halt_en in DSKCON deasserts both halt_n and nmi_n on the next edge.

a_regint is combinational from the flags.

Asynchronous reset mid-transfer returns every output to its reset value immediately.

Test Plan:
1. Command path: CoCo writes 0x80 to $FF48. Expect busy=1, cmd_pending=1 and a_regint=1. AVR reads reg1: expect 0x80, cmd_pending=0, a_regint=0. CoCo reads $FF48: expect bit0=1.
2. Read-sector handshake: DSKCON=0x80 with busy=1. Expect halt_n=0 within 1 cycle. AVR writes 0x5A to reg4: expect drq=1 and halt_n=1 next cycle. CoCo reads $FF4B: expect 0x5A, drq=0, xfer_evt=1, halt_n=0 again. AVR reads reg6: expect xfer_evt cleared.
3. Completion NMI: AVR writes 0x01 to reg6 with halt_en=1. Expect busy=0, intrq=1, nmi_n=0 next cycle. CoCo reads STATUS: expect nmi_n=1 one cycle later.
4. Force interrupt: CoCo writes 0xD8 while busy=1 and drq=1. Expect busy=0, drq=0, intrq=1, nmi_n=0. A 0xD0 write instead leaves intrq=0.
5. HALT timeout: halt_en=1, busy=1, no AVR data, HALT_TIMEOUT=16. Expect halt_n low for exactly 16 cycles, then lost=1, STATUS bit2=1, intrq=1, nmi_n=0.
6. Collisions and reset: CoCo and AVR write TRACK in the same cycle: expect the CoCo value. Assert reset while halt_n=0 and nmi_n=0: expect both 1 immediately and all registers 0.
